apb_master: RTL and testbench

APB bridge between the RISC-V core's data-memory port and the APB peripheral bus. Each CPU load/store becomes one APB transfer (SETUP then ACCESS). Five slave slots are decoded; slot 0 is the data RAM. Adds unmapped-address and slave-timeout error completion so the core never hangs.

---
 rtl/apb_master_if.sv | 39 +++
 rtl/apb_master.sv | 129 ++++++++++++
 tb/tb_apb_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// CPU data-port and APB peripheral-bus signals of the apb_master bridge.
// master: the bridge side; slave: the CPU + peripheral side.
interface apb_master_if;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  strb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [2:0]  PSTRB;
    logic        PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4;
    logic        PREADY0, PREADY1, PREADY2, PREADY3, PREADY4;

    modport master (
        input  transfer, write, addr, wdata, strb,
        output rdata, ready, err,
        output PADDR, PWRITE, PWDATA, PSTRB, PENABLE,
        output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        input  PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );

    modport slave (
        output transfer, write, addr, wdata, strb,
        input  rdata, ready, err,
        input  PADDR, PWRITE, PWDATA, PSTRB, PENABLE,
        input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        output PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );
endinterface

// File: rtl/apb_master.sv
// CPU load/store to APB bridge: five decoded slots, unmapped-address and
// slave-timeout error completion so the core is never left waiting.
module apb_master #(
    parameter int TIMEOUT = 255
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master bus
);

    // state  | meaning
    // IDLE   | waiting for a CPU transfer request
    // SETUP  | PSEL asserted, PENABLE low
    // ACCESS | PENABLE high, waiting for PREADY / unmapped / timeout
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [4:0]  r_sel;
    logic [31:0] r_paddr, r_pwdata;
    logic        r_pwrite;
    logic [2:0]  r_pstrb;

    logic [4:0]  w_dec;
    logic        w_active, w_mapped, w_sel_ready, w_timeout;
    logic [31:0] w_sel_rdata;
    logic        w_ready, w_err;
    logic [31:0] w_rdata;

    always_comb begin
        w_dec = 5'b00000;
        case (bus.addr[31:12])
            20'h10000: w_dec = 5'b00001;
            20'h10001: w_dec = 5'b00010;
            20'h10002: w_dec = 5'b00100;
            20'h10003: w_dec = 5'b01000;
            20'h10004: w_dec = 5'b10000;
            default:   w_dec = 5'b00000;
        endcase
    end

    // r_sel is one-hot for a mapped slot and all-zero for an unmapped address
    assign w_mapped    = |r_sel;
    assign w_sel_ready = |(r_sel & {bus.PREADY4, bus.PREADY3, bus.PREADY2,
                                    bus.PREADY1, bus.PREADY0});
    assign w_sel_rdata = ({32{r_sel[0]}} & bus.PRDATA0) |
                         ({32{r_sel[1]}} & bus.PRDATA1) |
                         ({32{r_sel[2]}} & bus.PRDATA2) |
                         ({32{r_sel[3]}} & bus.PRDATA3) |
                         ({32{r_sel[4]}} & bus.PRDATA4);
    assign w_timeout   = (r_cnt == C_TO_LAST);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_rdata = 32'd0;
        case (r_state)
            ST_IDLE:  if (bus.transfer) w_next = ST_SETUP;
            ST_SETUP: w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (!w_mapped) begin
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_sel_ready) begin
                    w_ready = 1'b1;
                    w_rdata = w_sel_rdata;
                    w_next  = ST_IDLE;
                end else if (w_timeout) begin
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_SETUP) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_ACCESS && w_next == ST_ACCESS) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // request fields are held through IDLE until the next accepted transfer
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_paddr  <= 32'd0;
            r_pwdata <= 32'd0;
            r_pwrite <= 1'b0;
            r_pstrb  <= 3'd0;
            r_sel    <= 5'd0;
        end else if (r_state == ST_IDLE && bus.transfer) begin
            r_paddr  <= bus.addr;
            r_pwdata <= bus.wdata;
            r_pwrite <= bus.write;
            r_pstrb  <= bus.strb;
            r_sel    <= w_dec;
        end
    end

    assign w_active    = (r_state != ST_IDLE);
    assign bus.PSEL0   = w_active & r_sel[0];
    assign bus.PSEL1   = w_active & r_sel[1];
    assign bus.PSEL2   = w_active & r_sel[2];
    assign bus.PSEL3   = w_active & r_sel[3];
    assign bus.PSEL4   = w_active & r_sel[4];
    assign bus.PENABLE = (r_state == ST_ACCESS);
    assign bus.PADDR   = r_paddr;
    assign bus.PWDATA  = r_pwdata;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PSTRB   = r_pstrb;
    assign bus.ready   = w_ready;
    assign bus.err     = w_err;
    assign bus.rdata   = w_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4) with RAM, wait-state, stuck and
// zero-wait slave models on the five slots.
module tb_apb_master;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   total = 0;
    int   bad = 0;

    apb_master_if bus ();

    apb_master #(.TIMEOUT(4)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    logic [4:0]  psel;
    assign psel = {bus.PSEL4, bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

    // slot0 RAM: PREADY one cycle after PSEL&PENABLE is seen
    logic [31:0] mem [16];
    logic        ram_rdy;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) ram_rdy <= 1'b0;
        else        ram_rdy <= bus.PSEL0 & bus.PENABLE & ~ram_rdy;
    end
    always_ff @(posedge PCLK) begin
        if (bus.PSEL0 && bus.PENABLE && bus.PREADY0 && bus.PWRITE)
            mem[bus.PADDR[5:2]] <= bus.PWDATA;
    end
    assign bus.PREADY0 = ram_rdy;
    assign bus.PRDATA0 = mem[bus.PADDR[5:2]];

    // slot2: three ACCESS wait cycles
    logic [2:0] s2_cnt;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                      s2_cnt <= 3'd0;
        else if (bus.PSEL2 && bus.PENABLE) s2_cnt <= s2_cnt + 3'd1;
        else                             s2_cnt <= 3'd0;
    end
    assign bus.PREADY2 = bus.PSEL2 & bus.PENABLE & (s2_cnt == 3'd3);
    assign bus.PRDATA2 = 32'h1234_5678;

    // slot1 and slot3 never ready; slot4 always ready
    assign bus.PREADY1 = 1'b0;
    assign bus.PRDATA1 = 32'h1111_1111;
    assign bus.PREADY3 = 1'b0;
    assign bus.PRDATA3 = 32'h3333_3333;
    assign bus.PREADY4 = 1'b1;
    assign bus.PRDATA4 = 32'hA5A5_0004;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // drives a request over edge 0; returns in cycle 1 (SETUP)
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s);
        bus.transfer = 1'b1;
        bus.write    = w;
        bus.addr     = a;
        bus.wdata    = d;
        bus.strb     = s;
        step();
        bus.transfer = 1'b0;
        bus.addr     = 32'hFFFF_FFFF;
        bus.wdata    = 32'h0;
        bus.strb     = 3'd7;
    endtask

    initial begin
        int pen_n, rdy_n, set_n;
        logic [31:0] cap;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        bus.strb     = 3'd0;
        step();
        step();
        chk("rst_psel", psel, 5'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_paddr", bus.PADDR, 32'h0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_pwrite", bus.PWRITE, 1'b0);
        chk("rst_pstrb", bus.PSTRB, 3'd0);
        chk("rst_ready_err", {bus.ready, bus.err}, 2'b00);
        chk("rst_rdata", bus.rdata, 32'h0);
        PRESET = 1'b0;
        step();

        // RAM store then load
        issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 3'b010);
        chk("st_setup_psel", psel, 5'b00001);
        chk("st_setup_penable", bus.PENABLE, 1'b0);
        chk("st_paddr", bus.PADDR, 32'h1000_0010);
        chk("st_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        chk("st_pwrite", bus.PWRITE, 1'b1);
        chk("st_pstrb", bus.PSTRB, 3'b010);
        step();
        chk("st_c2_penable", bus.PENABLE, 1'b1);
        chk("st_c2_ready", bus.ready, 1'b0);
        step();
        chk("st_c3_ready_err", {bus.ready, bus.err}, 2'b10);
        step();
        chk("st_c4_idle_psel", psel, 5'b0);
        chk("st_c4_ready", bus.ready, 1'b0);
        chk("st_c4_paddr_held", bus.PADDR, 32'h1000_0010);

        issue(1'b0, 32'h1000_0010, 32'h0, 3'b100);
        chk("ld_pstrb", bus.PSTRB, 3'b100);
        chk("ld_pwrite", bus.PWRITE, 1'b0);
        step();
        chk("ld_c2_ready", bus.ready, 1'b0);
        step();
        chk("ld_c3_ready_err", {bus.ready, bus.err}, 2'b10);
        chk("ld_c3_rdata", bus.rdata, 32'hDEAD_BEEF);
        step();

        // slot2 with three wait cycles
        issue(1'b0, 32'h1000_2004, 32'h0, 3'b010);
        chk("s2_psel", psel, 5'b00100);
        pen_n = 0; rdy_n = 0; cap = 32'h0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.PENABLE) pen_n++;
            if (bus.ready) begin
                rdy_n++;
                cap = bus.rdata;
            end
        end
        chk("s2_penable_cycles", 32'(pen_n), 32'd4);
        chk("s2_ready_cycles", 32'(rdy_n), 32'd1);
        chk("s2_rdata", cap, 32'h1234_5678);

        // unmapped address
        issue(1'b0, 32'h2000_0000, 32'h0, 3'b010);
        chk("um_c1_psel", psel, 5'b0);
        step();
        chk("um_c2_psel", psel, 5'b0);
        chk("um_c2_ready_err", {bus.ready, bus.err}, 2'b11);
        chk("um_c2_rdata", bus.rdata, 32'h0);
        step();
        chk("um_c3_idle", {bus.PENABLE, bus.ready}, 2'b00);

        // slot4 zero-wait
        issue(1'b0, 32'h1000_4008, 32'h0, 3'b010);
        step();
        chk("s4_c2_ready_err", {bus.ready, bus.err}, 2'b10);
        chk("s4_c2_rdata", bus.rdata, 32'hA5A5_0004);
        step();
        chk("s4_c3_idle", bus.PENABLE, 1'b0);

        // slot3 timeout (TIMEOUT=4): error in the 4th ACCESS cycle
        issue(1'b0, 32'h1000_3000, 32'h0, 3'b010);
        step();
        step();
        step();
        chk("to_c4_ready", bus.ready, 1'b0);
        chk("to_c4_psel", psel, 5'b01000);
        step();
        chk("to_c5_ready_err", {bus.ready, bus.err}, 2'b11);
        chk("to_c5_rdata", bus.rdata, 32'h0);
        step();
        chk("to_c6_idle", {bus.PENABLE, psel}, 6'b0);
        issue(1'b0, 32'h1000_0010, 32'h0, 3'b010);
        step();
        step();
        chk("to_ram_ready_err", {bus.ready, bus.err}, 2'b10);
        chk("to_ram_rdata", bus.rdata, 32'hDEAD_BEEF);
        step();

        // second transfer pulse during ACCESS is ignored
        issue(1'b1, 32'h1000_0020, 32'h0BAD_F00D, 3'b010);
        step();
        bus.transfer = 1'b1;
        bus.addr     = 32'h1000_0030;
        set_n = 0; rdy_n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) bus.transfer = 1'b0;
            if (psel != 5'b0 && !bus.PENABLE) set_n++;
            if (bus.ready) rdy_n++;
        end
        chk("dbl_extra_setups", 32'(set_n), 32'd0);
        chk("dbl_ready_cycles", 32'(rdy_n), 32'd1);
        chk("dbl_paddr", bus.PADDR, 32'h1000_0020);

        // reset during slot1 write ACCESS
        issue(1'b1, 32'h1000_1004, 32'h5555_AAAA, 3'b010);
        step();
        chk("rm_c2_psel", psel, 5'b00010);
        step();
        PRESET = 1'b1;
        #1;
        chk("rm_psel", psel, 5'b0);
        chk("rm_penable", bus.PENABLE, 1'b0);
        chk("rm_paddr", bus.PADDR, 32'h0);
        chk("rm_pwdata", bus.PWDATA, 32'h0);
        chk("rm_pwrite_pstrb", {bus.PWRITE, bus.PSTRB}, 4'b0);
        chk("rm_ready_err", {bus.ready, bus.err}, 2'b00);
        step();
        chk("rm_held_ready", {bus.ready, psel}, 6'b0);
        PRESET = 1'b0;
        step();
        issue(1'b0, 32'h1000_0020, 32'h0, 3'b010);
        chk("rm_new_psel", psel, 5'b00001);
        step();
        step();
        chk("rm_new_ready_err", {bus.ready, bus.err}, 2'b10);
        chk("rm_new_rdata", bus.rdata, 32'h0BAD_F00D);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
